vc_pop_arbiter: RTL
===================

VC_POP_ARBITER -- requirements
Module: vc_pop_arbiter

Interface
REQ-001 Parameter DATA_SIZE, default 6, word width of VC FIFO head words.
REQ-002 Parameter DEST_BIT, default 4, head-word bit index selecting destination (0 -> D0, 1 -> D1).
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 reset_L  input  1  reset; asynchronous, active-low.
REQ-005 init  input  1  forces INIT state while high.
REQ-006 vc0_empty, vc1_empty  input  1 each  VC0/VC1 FIFO empty flags.
REQ-007 vc0_head, vc1_head  input  DATA_SIZE each  word the next pop removes from VC0/VC1.
REQ-008 d0_almost_full, d1_almost_full  input  1 each  downstream destination FIFO almost-full flags.
REQ-009 pop_vc0, pop_vc1  output  1 each  combinational pop strobes to VC0/VC1 FIFOs.
REQ-010 pop_delay_vc0, pop_delay_vc1  output  1 each  pop strobes registered one cycle; drive the VC mux enables.
REQ-011 state  output  2  current FSM state: 00 RESET, 01 INIT, 10 IDLE, 11 ACTIVE.
REQ-012 idle_out  output  1  high when state is IDLE.
REQ-013 pop_count  output  8  registered running count of issued pops.

Function
REQ-014 FSM transitions, one per clock: RESET -> INIT; INIT -> IDLE when init low; IDLE -> ACTIVE when either VC not empty; ACTIVE -> IDLE when both VCs empty and both pop_delay low.
REQ-015 init high in any non-RESET state -> INIT next cycle; init has priority over all other transitions.
REQ-016 Pops only in ACTIVE; pop_vc0 and pop_vc1 are 0 in RESET, INIT, IDLE.
REQ-017 VCn eligible when vcn_empty low and the almost_full of the destination selected by vcn_head[DEST_BIT] is low.
REQ-018 At most one of pop_vc0/pop_vc1 high in any cycle.
REQ-019 Default arbitration: strict priority; VC0 wins whenever eligible, VC1 pops only when VC0 not eligible.
REQ-020 VC0 ineligible (blocked destination) does not block an eligible VC1; no head-of-line coupling between VCs.
REQ-021 pop_delay_vcn equals pop_vcn of the previous cycle; latency exactly 1 clock.
REQ-022 Pop in cycle N, state change to IDLE/INIT in N+1: pop_delay for N still asserts in N+1.
REQ-023 pop_count increments by 1 on each clock where a pop is issued; wraps 255 -> 0; holds otherwise, including in INIT.
REQ-024 idle_out is a decode of state, no extra latency.

Reset
REQ-025 reset_L low: state = RESET, pop_delay_vc0/vc1 = 0, pop_count = 0, idle_out = 0, pops = 0, asynchronously and independent of clk.
REQ-026 Reset asserted mid-burst discards in-flight pop_delay immediately; first cycle after release state goes RESET -> INIT.

Configuration
REQ-027 Macro VC_ROUND_ROBIN_EN defined: when both VCs eligible, grant alternates, starting with VC0 after reset, using a 1-bit last-grant register updated only on issued pops; single-eligible VC always granted.
REQ-028 VC_ROUND_ROBIN_EN undefined: strict VC0 priority per REQ-019; no last-grant register exists.

Verification
REQ-029 reset_L low 3 cycles, init high 2 cycles then low, VCs empty -> state 00,01,01,10 then holds 10; idle_out 1; pop_count 0.
REQ-030 IDLE, vc0 holds 3 words with DEST_BIT=0, d0_almost_full 0 -> ACTIVE next cycle, pop_vc0 high 3 consecutive cycles, pop_delay_vc0 same 3 cycles shifted +1, pop_count 3, return to IDLE.
REQ-031 Both VCs non-empty, all to D0, no almost-full, macro undefined -> all VC0 pops precede any VC1 pop; macro defined -> pops alternate VC0,VC1,VC0,...
REQ-032 vc0_head[4]=1 with d1_almost_full 1, vc1_head[4]=0 with d0_almost_full 0 -> pop_vc1 only; drop d1_almost_full -> pop_vc0 next cycle.
REQ-033 Mid-burst reset_L low between edges -> pop_delay_vc0 and pop_count 0 without clock edge; init high in ACTIVE -> INIT next cycle, no pops issued.
REQ-034 256 pops -> pop_count wraps to 0; checker asserts pop_vc0 & pop_vc1 never both high.

Source files
------------

// File: rtl/vc_pop_arbiter_if.sv
// vc_pop_arbiter_if: FIFO-status inputs and pop/status outputs of the VC pop arbiter.
// Latency: wires only, no state.
// Backpressure: carries the destination almost-full flags that gate pops.
//
// Signals:
//   init                           - force INIT state while high
//   vc0_empty, vc1_empty           - VC FIFO empty flags
//   vc0_head, vc1_head             - word the next pop removes from each VC
//   d0_almost_full, d1_almost_full - downstream destination almost-full flags
//   pop_vc0, pop_vc1               - combinational pop strobes
//   pop_delay_vc0, pop_delay_vc1   - pop strobes delayed one clock
//   state, idle_out, pop_count     - FSM state, IDLE decode, running pop count
// Modports: master = arbiter side, slave = FIFO/environment side.
interface vc_pop_arbiter_if #(
  parameter int DATA_SIZE = 6
);
  logic                 init;
  logic                 vc0_empty;
  logic                 vc1_empty;
  logic [DATA_SIZE-1:0] vc0_head;
  logic [DATA_SIZE-1:0] vc1_head;
  logic                 d0_almost_full;
  logic                 d1_almost_full;
  logic                 pop_vc0;
  logic                 pop_vc1;
  logic                 pop_delay_vc0;
  logic                 pop_delay_vc1;
  logic [1:0]           state;
  logic                 idle_out;
  logic [7:0]           pop_count;

  modport master (
    input  init, vc0_empty, vc1_empty, vc0_head, vc1_head,
           d0_almost_full, d1_almost_full,
    output pop_vc0, pop_vc1, pop_delay_vc0, pop_delay_vc1,
           state, idle_out, pop_count
  );

  modport slave (
    output init, vc0_empty, vc1_empty, vc0_head, vc1_head,
           d0_almost_full, d1_almost_full,
    input  pop_vc0, pop_vc1, pop_delay_vc0, pop_delay_vc1,
           state, idle_out, pop_count
  );
endinterface

// File: rtl/vc_pop_arbiter.sv
// vc_pop_arbiter: pops at most one of two VC FIFOs per clock toward two destinations.
// Latency: pop strobes combinational from inputs; pop_delay/pop_count/state registered (1 clk).
// Backpressure: a VC is only popped when its head's destination is not almost-full.
//
// Ports:
//   clk     - rising-edge clock
//   reset_L - asynchronous active-low reset
//   bus     - vc_pop_arbiter_if.master (FIFO status in, pop strobes and status out)
// Parameters: DATA_SIZE (head word width), DEST_BIT (head bit selecting D0/D1).
// Build option: define VC_ROUND_ROBIN_EN to alternate grants between VCs when both
// are eligible; otherwise VC0 has strict priority.
module vc_pop_arbiter #(
  parameter int DATA_SIZE = 6,
  parameter int DEST_BIT  = 4
) (
  input  logic              clk,
  input  logic              reset_L,
  vc_pop_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'b00,
    ST_INIT   = 2'b01,
    ST_IDLE   = 2'b10,
    ST_ACTIVE = 2'b11
  } state_t;

  state_t               state_q;
  logic                 pop_delay_vc0_q;
  logic                 pop_delay_vc1_q;
  logic [7:0]           pop_count_q;

  logic [DATA_SIZE-1:0] vc0_head_w;
  logic [DATA_SIZE-1:0] vc1_head_w;
  logic                 vc0_elig;
  logic                 vc1_elig;
  logic                 grant_vc0;
  logic                 grant_vc1;
  logic                 pop0;
  logic                 pop1;
  logic                 any_pending;

  assign vc0_head_w = bus.vc0_head;
  assign vc1_head_w = bus.vc1_head;

  // Each VC is judged only against its own head's destination, so a blocked
  // VC0 never holds back an eligible VC1.
  assign vc0_elig = !bus.vc0_empty &&
                    !(vc0_head_w[DEST_BIT] ? bus.d1_almost_full : bus.d0_almost_full);
  assign vc1_elig = !bus.vc1_empty &&
                    !(vc1_head_w[DEST_BIT] ? bus.d1_almost_full : bus.d0_almost_full);

`ifdef VC_ROUND_ROBIN_EN
  // High when the most recent issued pop went to VC0; resets low so the first
  // contested grant after reset goes to VC0.
  logic last_vc0_q;

  always_comb begin
    grant_vc0 = 1'b0;
    grant_vc1 = 1'b0;
    if (vc0_elig && vc1_elig) begin
      grant_vc0 = !last_vc0_q;
      grant_vc1 = last_vc0_q;
    end else begin
      grant_vc0 = vc0_elig;
      grant_vc1 = vc1_elig;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      last_vc0_q <= 1'b0;
    end else if (pop0) begin
      last_vc0_q <= 1'b1;
    end else if (pop1) begin
      last_vc0_q <= 1'b0;
    end
  end
`else
  assign grant_vc0 = vc0_elig;
  assign grant_vc1 = vc1_elig && !vc0_elig;
`endif

  assign pop0 = (state_q == ST_ACTIVE) && grant_vc0;
  assign pop1 = (state_q == ST_ACTIVE) && grant_vc1;

  // ACTIVE is held while any VC has data or a pop is still travelling through
  // the delayed strobes, so the mux enables finish before going IDLE.
  assign any_pending = !bus.vc0_empty || !bus.vc1_empty ||
                       pop_delay_vc0_q || pop_delay_vc1_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q         <= ST_RESET;
      pop_delay_vc0_q <= 1'b0;
      pop_delay_vc1_q <= 1'b0;
      pop_count_q     <= 8'd0;
    end else begin
      pop_delay_vc0_q <= pop0;
      pop_delay_vc1_q <= pop1;
      if (pop0 || pop1) begin
        pop_count_q <= pop_count_q + 8'd1;
      end
      if (state_q == ST_RESET) begin
        state_q <= ST_INIT;
      end else if (bus.init) begin
        state_q <= ST_INIT;
      end else begin
        case (state_q)
          ST_INIT:   state_q <= ST_IDLE;
          ST_IDLE:   state_q <= (!bus.vc0_empty || !bus.vc1_empty) ? ST_ACTIVE : ST_IDLE;
          ST_ACTIVE: state_q <= any_pending ? ST_ACTIVE : ST_IDLE;
          default:   state_q <= ST_RESET;
        endcase
      end
    end
  end

  assign bus.pop_vc0       = pop0;
  assign bus.pop_vc1       = pop1;
  assign bus.pop_delay_vc0 = pop_delay_vc0_q;
  assign bus.pop_delay_vc1 = pop_delay_vc1_q;
  assign bus.pop_count     = pop_count_q;
  assign bus.state         = state_q;
  assign bus.idle_out      = (state_q == ST_IDLE);

endmodule
